// File: rtl/pc_fetch_control_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_control_if
//   Signal bundle between the fetch controller and its neighbours (PC+4 adder,
//   instruction memory, jump/branch resolution, hazard unit, decode).
//
//   Handshake: there is no valid/ready pair on the fetch address itself.
//   FetchValid qualifies PCResult: the instruction at PCResult is issued in
//   every cycle FetchValid is high. IMemReady is the memory's acceptance
//   signal; while it is low the controller holds PCResult and keeps
//   FetchValid low. Both sides sample on the rising clock edge.
//
//   Signals
//     PCAddResult  [31:0]          PCResult+4 from the adder
//     JumpTarget   [31:0]          jump destination
//     Jump                         take jump this cycle
//     BranchTarget [31:0]          branch destination
//     BranchTaken                  take branch this cycle
//     Stall                        hazard hold request
//     IMemReady                    instruction memory accepts the address
//     PCResult     [31:0]          current fetch address (registered)
//     FetchValid                   instruction at PCResult issued this cycle
//     Flush                        one-cycle pulse after a redirect
//     StallCycles  [STALL_CNT_W-1:0] saturating count of hold cycles
//     Misaligned                   sticky misaligned-target flag
//     fsm_state    [1:0]           debug view of the sequencing FSM
//
//   Modports
//     master : environment side (drives the requests, observes the PC)
//     slave  : the fetch controller
// ---------------------------------------------------------------------------
interface pc_fetch_control_if #(
   parameter int STALL_CNT_W = 16
);
   logic [31:0]            PCAddResult;
   logic [31:0]            JumpTarget;
   logic                   Jump;
   logic [31:0]            BranchTarget;
   logic                   BranchTaken;
   logic                   Stall;
   logic                   IMemReady;
   logic [31:0]            PCResult;
   logic                   FetchValid;
   logic                   Flush;
   logic [STALL_CNT_W-1:0] StallCycles;
   logic                   Misaligned;
   logic [1:0]             fsm_state;

   modport master (
      output PCAddResult, JumpTarget, Jump, BranchTarget, BranchTaken,
             Stall, IMemReady,
      input  PCResult, FetchValid, Flush, StallCycles, Misaligned, fsm_state
   );

   modport slave (
      input  PCAddResult, JumpTarget, Jump, BranchTarget, BranchTaken,
             Stall, IMemReady,
      output PCResult, FetchValid, Flush, StallCycles, Misaligned, fsm_state
   );
endinterface

// File: rtl/pc_fetch_control.sv
// ---------------------------------------------------------------------------
// pc_fetch_control
//   Program counter register, next-PC selection and fetch sequencing FSM.
//   Drives PCResult to the PC+4 adder and instruction memory, takes the
//   adder's result back as the sequential next address, and arbitrates
//   redirects (Jump > BranchTaken), holds (Stall or !IMemReady) and normal
//   progress. Every output comes straight from a flop.
//
//   Ports
//     Clk    rising-edge clock
//     Reset  synchronous, active-low reset
//     fc     pc_fetch_control_if.slave (see the interface for signal list)
//
//   Optional feature: define PC_MISALIGN_TRAP_EN to redirect any target
//   with bits[1:0] != 0 to TRAP_VECTOR and set the sticky Misaligned flag.
//   Without it targets load unmodified and Misaligned stays 0.
// ---------------------------------------------------------------------------
module pc_fetch_control #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080,
   parameter int          STALL_CNT_W = 16
) (
   input  logic                  Clk,
   input  logic                  Reset,
   pc_fetch_control_if.slave     fc
);

`ifdef PC_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_HOLD  = 2'd2,
      S_FLUSH = 2'd3
   } state_e;

   localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

   state_e                 state_q, state_d;
   logic [31:0]            pc_q, pc_d;
   logic                   fetch_valid_q, fetch_valid_d;
   logic                   flush_q, flush_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   misaligned_q, misaligned_d;

   logic                   redirect;
   logic                   hold;
   logic [31:0]            target;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_valid_d = 1'b0;
      flush_d       = 1'b0;
      stall_cnt_d   = stall_cnt_q;
      misaligned_d  = misaligned_q;

      redirect = fc.Jump | fc.BranchTaken;
      hold     = fc.Stall | ~fc.IMemReady;
      target   = fc.Jump ? fc.JumpTarget : fc.BranchTarget;

      if (redirect) begin
         // A misaligned target is swapped for the trap vector only when the
         // trap feature is compiled in; the FSM treats it like any redirect.
         if (TRAP_EN && (target[1:0] != 2'b00)) begin
            pc_d         = TRAP_VECTOR;
            misaligned_d = 1'b1;
         end else begin
            pc_d = target;
         end
         state_d = S_FLUSH;
         flush_d = 1'b1;
      end else if (hold) begin
         state_d = S_HOLD;
         if (stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
         end
      end else begin
         // Only a running pipeline advances; leaving BOOT/FLUSH/HOLD issues
         // the address already on PCResult exactly once.
         if (state_q == S_RUN) begin
            pc_d = fc.PCAddResult;
         end
         state_d       = S_RUN;
         fetch_valid_d = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q       <= S_BOOT;
         pc_q          <= RESET_PC;
         fetch_valid_q <= 1'b0;
         flush_q       <= 1'b0;
         stall_cnt_q   <= '0;
         misaligned_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_valid_q <= fetch_valid_d;
         flush_q       <= flush_d;
         stall_cnt_q   <= stall_cnt_d;
         misaligned_q  <= misaligned_d;
      end
   end

   assign fc.PCResult    = pc_q;
   assign fc.FetchValid  = fetch_valid_q;
   assign fc.Flush       = flush_q;
   assign fc.StallCycles = stall_cnt_q;
   assign fc.Misaligned  = misaligned_q;
   assign fc.fsm_state   = state_q;

endmodule

// File: tb/tb_pc_fetch_control.sv
module tb_pc_fetch_control;

   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR = 32'h0000_0080;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        jump, br, stall, ready;
   logic [31:0] jt, bt;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // ---------------- DUTs ----------------
   pc_fetch_control_if #(.STALL_CNT_W(16)) bus ();
   pc_fetch_control_if #(.STALL_CNT_W(3))  bus_s ();

   assign bus.PCAddResult  = bus.PCResult + 32'd4;
   assign bus.JumpTarget   = jt;
   assign bus.Jump         = jump;
   assign bus.BranchTarget = bt;
   assign bus.BranchTaken  = br;
   assign bus.Stall        = stall;
   assign bus.IMemReady    = ready;

   assign bus_s.PCAddResult  = bus_s.PCResult + 32'd4;
   assign bus_s.JumpTarget   = jt;
   assign bus_s.Jump         = jump;
   assign bus_s.BranchTarget = bt;
   assign bus_s.BranchTaken  = br;
   assign bus_s.Stall        = stall;
   assign bus_s.IMemReady    = ready;

   pc_fetch_control #(
      .RESET_PC(RESET_PC), .TRAP_VECTOR(TRAP_VECTOR), .STALL_CNT_W(16)
   ) dut (
      .Clk(clk), .Reset(rst_n), .fc(bus.slave)
   );

   // Narrow counter copy so saturation is reachable in a short run.
   pc_fetch_control #(
      .RESET_PC(RESET_PC), .TRAP_VECTOR(TRAP_VECTOR), .STALL_CNT_W(3)
   ) dut_s (
      .Clk(clk), .Reset(rst_n), .fc(bus_s.slave)
   );

   // ---------------- behavioural model ----------------
   // Tracks what the fetch unit must show: current address, whether it was
   // issued, whether a redirect just happened, hold count and sticky flag.
   logic [31:0] m_pc;
   logic        m_fv, m_flush, m_mis;
   int          m_cnt, m_cnt_s;

   always @(posedge clk) begin : model
      logic [31:0] t;
      if (!rst_n) begin
         m_pc <= RESET_PC; m_fv <= 1'b0; m_flush <= 1'b0;
         m_cnt <= 0; m_cnt_s <= 0; m_mis <= 1'b0;
      end else if (jump || br) begin
         t = jump ? jt : bt;
`ifdef PC_MISALIGN_TRAP_EN
         if (t[1:0] != 2'b00) begin
            t = TRAP_VECTOR;
            m_mis <= 1'b1;
         end
`endif
         m_pc <= t; m_fv <= 1'b0; m_flush <= 1'b1;
      end else if (stall || !ready) begin
         m_fv <= 1'b0; m_flush <= 1'b0;
         m_cnt   <= (m_cnt   < 65535) ? m_cnt + 1   : m_cnt;
         m_cnt_s <= (m_cnt_s < 7)     ? m_cnt_s + 1 : m_cnt_s;
      end else begin
         // Address advances only if it was already issued last cycle.
         if (m_fv) m_pc <= m_pc + 32'd4;
         m_fv <= 1'b1; m_flush <= 1'b0;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc",          bus.PCResult,                m_pc);
         chk("fetch_valid", 32'(bus.FetchValid),         32'(m_fv));
         chk("flush",       32'(bus.Flush),              32'(m_flush));
         chk("stall_cnt",   32'(bus.StallCycles),        32'(m_cnt));
         chk("misaligned",  32'(bus.Misaligned),         32'(m_mis));
         chk("stall_cnt_w3", 32'(bus_s.StallCycles),     32'(m_cnt_s));
         chk("pc_w3",       bus_s.PCResult,              m_pc);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle();
      jump = 1'b0; br = 1'b0; stall = 1'b0; ready = 1'b1;
   endtask

   task automatic expect_out(input string name, input logic [31:0] pc,
                             input logic fv, input logic fl);
      chk({name, "_pc"}, bus.PCResult, pc);
      chk({name, "_fv"}, 32'(bus.FetchValid), 32'(fv));
      chk({name, "_flush"}, 32'(bus.Flush), 32'(fl));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; jt = '0; bt = '0;
      idle();
      step();
      chk_en = 1'b1;
      step();
      expect_out("reset", 32'h0, 1'b0, 1'b0);
      chk("reset_cnt", 32'(bus.StallCycles), 32'h0);

      // boot sequence
      rst_n = 1'b1;
      step(); expect_out("boot0", 32'h0, 1'b1, 1'b0);
      step(); expect_out("boot4", 32'h4, 1'b1, 1'b0);
      step(); expect_out("boot8", 32'h8, 1'b1, 1'b0);
      step(); step(); expect_out("run10", 32'h10, 1'b1, 1'b0);

      // jump beats branch
      jump = 1'b1; jt = 32'h200; br = 1'b1; bt = 32'h300;
      step(); expect_out("jmp_redir", 32'h200, 1'b0, 1'b1);
      idle();
      step(); expect_out("jmp_issue", 32'h200, 1'b1, 1'b0);
      step(); expect_out("jmp_next", 32'h204, 1'b1, 1'b0);

      // stall for three cycles at 0x40
      jump = 1'b1; jt = 32'h40;
      step(); idle();
      step(); expect_out("at40", 32'h40, 1'b1, 1'b0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); expect_out("stall_hold", 32'h40, 1'b0, 1'b0);
      end
      chk("stall_cnt3", 32'(bus.StallCycles), 32'd3);
      stall = 1'b0;
      step(); expect_out("stall_issue", 32'h40, 1'b1, 1'b0);
      step(); expect_out("stall_next", 32'h44, 1'b1, 1'b0);

      // memory wait while flushing after a branch
      br = 1'b1; bt = 32'h100;
      step(); expect_out("br_redir", 32'h100, 1'b0, 1'b1);
      br = 1'b0; ready = 1'b0;
      step(); expect_out("br_wait", 32'h100, 1'b0, 1'b0);
      ready = 1'b1;
      step(); expect_out("br_issue", 32'h100, 1'b1, 1'b0);
      step(); expect_out("br_next", 32'h104, 1'b1, 1'b0);

      // wrap-around
      jump = 1'b1; jt = 32'hFFFF_FFFC;
      step(); idle();
      step(); expect_out("wrap_top", 32'hFFFF_FFFC, 1'b1, 1'b0);
      step(); expect_out("wrap_zero", 32'h0, 1'b1, 1'b0);

      // reset in the middle of a stall
      stall = 1'b1;
      step(); step();
      rst_n = 1'b0;
      step(); expect_out("rst_mid", RESET_PC, 1'b0, 1'b0);
      chk("rst_mid_cnt", 32'(bus.StallCycles), 32'h0);
      rst_n = 1'b1; stall = 1'b0;
      step(); expect_out("rst_boot", RESET_PC, 1'b1, 1'b0);

      // back-to-back redirects
      jump = 1'b1; jt = 32'h500;
      step(); expect_out("b2b_a", 32'h500, 1'b0, 1'b1);
      jump = 1'b0; br = 1'b1; bt = 32'h600;
      step(); expect_out("b2b_b", 32'h600, 1'b0, 1'b1);
      idle();
      step(); expect_out("b2b_issue", 32'h600, 1'b1, 1'b0);

      // misaligned branch target
      br = 1'b1; bt = 32'h102;
      step();
`ifdef PC_MISALIGN_TRAP_EN
      expect_out("mis_redir", 32'h80, 1'b0, 1'b1);
      chk("mis_flag", 32'(bus.Misaligned), 32'h1);
`else
      expect_out("mis_redir", 32'h102, 1'b0, 1'b1);
      chk("mis_flag", 32'(bus.Misaligned), 32'h0);
`endif
      idle();
      step(); step();
`ifdef PC_MISALIGN_TRAP_EN
      chk("mis_sticky", 32'(bus.Misaligned), 32'h1);
`else
      chk("mis_sticky", 32'(bus.Misaligned), 32'h0);
`endif

      // long hold to saturate the narrow counter
      stall = 1'b1;
      for (int i = 0; i < 10; i++) step();
      chk("sat_w3", 32'(bus_s.StallCycles), 32'd7);
      stall = 1'b0;

      // randomized traffic, checked every cycle by the scoreboard
      for (int i = 0; i < 3000; i++) begin
         jump  = ($urandom_range(0, 7) == 0);
         br    = ($urandom_range(0, 7) == 0);
         stall = ($urandom_range(0, 3) == 0);
         ready = ($urandom_range(0, 3) != 0);
         rst_n = ($urandom_range(0, 99) != 0);
         jt = $urandom_range(0, 15) == 0 ? 32'hFFFF_FFF0 | ($urandom & 32'hC)
                                         : ($urandom & 32'hFFFF_FFFC);
         bt = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 9) == 0) jt[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) bt[1:0] = 2'($urandom_range(1, 3));
         step();
      end

      idle(); rst_n = 1'b1;
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_control.md
Name: pc_fetch_control

Overview:
- Program counter register plus next-PC selection and fetch-sequencing FSM. Sits directly upstream of the PC+4 adder.
- Drives PCResult into the adder and the instruction memory.
- Consumes PCAddResult back from the adder as the sequential next address.
- Arbitrates jump/branch redirects, hazard stalls and instruction-memory wait states; signals bubbles to decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0080, redirect address for a misaligned target (used only with PC_MISALIGN_TRAP_EN).
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-low reset; sampled on the Clk rising edge.
- PCAddResult  input  32  PCResult+4 from the adder.
- JumpTarget  input  32  jump destination.
- Jump  input  1  take jump this cycle.
- BranchTarget  input  32  branch destination.
- BranchTaken  input  1  take branch this cycle.
- Stall  input  1  hazard unit hold request.
- IMemReady  input  1  instruction memory can accept the address this cycle.
- PCResult  output  32  current fetch address (registered).
- FetchValid  output  1  high when the instruction at PCResult is issued this cycle.
- Flush  output  1  one-cycle pulse after a redirect; decode discards its instruction.
- StallCycles  output  STALL_CNT_W  saturating count of cycles spent in S_HOLD.
- Misaligned  output  1  sticky misaligned-target flag (PC_MISALIGN_TRAP_EN only; otherwise tied 0).

Behaviour:
- All outputs are registered; all state updates occur on the Clk rising edge.
- Reset==0 at an edge, including mid-operation: PCResult<=RESET_PC, state<=S_BOOT, FetchValid<=0, Flush<=0, StallCycles<=0, Misaligned<=0. All other inputs are ignored.
- States: S_BOOT, S_RUN, S_HOLD, S_FLUSH. FetchValid==1 only in S_RUN.
- Priority at each edge with Reset==1: Jump > BranchTaken > (Stall | !IMemReady) > normal progress. Priority is identical in every state.
- Redirect (Jump, or BranchTaken without Jump):
  - PCResult<=selected target; state<=S_FLUSH; Flush<=1; FetchValid<=0.
  - Jump and BranchTaken both high: JumpTarget wins; only one Flush pulse.
  - Redirect during S_HOLD, S_FLUSH or S_BOOT is accepted identically.
- Hold (Stall==1 or IMemReady==0, no redirect):
  - PCResult holds; state<=S_HOLD; FetchValid<=0; Flush<=0.
  - StallCycles increments by 1, saturating at all-ones (no wrap).
- Normal progress (no redirect, no hold):
  - S_RUN: PCResult<=PCAddResult; stay in S_RUN.
  - S_BOOT, S_FLUSH, S_HOLD: PCResult holds, so the held or target address is fetched exactly once; state<=S_RUN; FetchValid<=1; Flush<=0.
- Flush is high for exactly one cycle per redirect. Back-to-back redirects give consecutive Flush pulses, each with its own target.
- Latency: a redirect asserted in cycle N puts the target on PCResult in cycle N+1 with FetchValid=0. The target is issued (FetchValid=1) in cycle N+2 if no hold occurs.
- Wrap-around: the block takes PCAddResult as-is; 32'hFFFF_FFFC advances to 32'h0000_0000 with no special handling.
- No combinational path from any input to any output.

Optional Feature:
- Macro PC_MISALIGN_TRAP_EN.
- Defined:
  - A redirect whose selected target has bits[1:0]!=0 loads TRAP_VECTOR instead of the target and sets Misaligned<=1.
  - Misaligned stays set until reset.
  - FSM and Flush behave as for any redirect.
- Undefined: targets are loaded unmodified; Misaligned is constant 0.

Test Plan:
- Reset=0 for 2 cycles, then 1, with Stall=0, IMemReady=1 and adder looped back -> PCResult=0, FetchValid=0 for the first cycle after release; then PCResult 0 with FetchValid=1, then 4, then 8.
- In S_RUN at PC=0x10, Jump=1 with JumpTarget=0x200 and BranchTaken=1 with BranchTarget=0x300, both for one cycle -> next cycle PCResult=0x200, Flush=1, FetchValid=0; following cycle PCResult=0x200, FetchValid=1; then 0x204.
- At PC=0x40, Stall=1 for 3 cycles -> PCResult held at 0x40, FetchValid=0 for 3 cycles, StallCycles=3; after release, 0x40 issued once with FetchValid=1, then 0x44.
- IMemReady=0 during S_FLUSH after a branch to 0x100 -> S_HOLD with PC=0x100; when IMemReady=1, 0x100 issued with no second Flush pulse.
- PC=0xFFFF_FFFC in S_RUN -> next PCResult=0x0000_0000, FetchValid=1. Reset=0 asserted mid-stall -> PCResult=RESET_PC, StallCycles=0, FSM restarts in S_BOOT.
- With PC_MISALIGN_TRAP_EN, BranchTaken=1, BranchTarget=0x102 -> PCResult=0x80, Misaligned=1 and sticky. Without the macro -> PCResult=0x102, Misaligned=0.
